// File: rtl/matrix_frame_sequencer_pkg.sv
// Shared types and constants for the LED matrix frame sequencer.
package matrix_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StFetch,
    StShift,
    StEnd,
    StHold
  } state_e;

  localparam int unsigned START_BITS  = 32;
  localparam int unsigned WORD_BITS   = 32;
  localparam int unsigned BIT_CYCLES  = 2;
  // clk cycles needed to stream one 32-bit word onto the strip
  localparam int unsigned WORD_CYCLES = WORD_BITS * BIT_CYCLES;

  // Zig-zag wiring: even rows run right-to-left, odd rows left-to-right.
  function automatic int unsigned serp_idx(input int unsigned p, input int unsigned row_len);
    int unsigned r;
    int unsigned c;
    r = p / row_len;
    c = p % row_len;
    return (r[0] == 1'b0) ? (r * row_len + row_len - 1 - c) : p;
  endfunction

endpackage

// File: rtl/matrix_frame_sequencer_if.sv
// Pixel-source handshake: sequencer requests a word, upstream source acks with it.
interface matrix_frame_sequencer_if #(
  parameter int unsigned IdxW   = 6,
  parameter int unsigned GlyphW = 2
) ();

  logic              pix_req;
  logic [IdxW-1:0]   pix_idx;
  logic [GlyphW-1:0] glyph_idx;
  logic              pix_ack;
  logic [31:0]       pix_word;

  modport master (output pix_req, pix_idx, glyph_idx, input pix_ack, pix_word);
  modport slave  (input pix_req, pix_idx, glyph_idx, output pix_ack, pix_word);

endinterface

// File: rtl/matrix_frame_sequencer_bit_shifter.sv
// Serialises a loaded word MSB first onto strip_clk/strip_data, 2 clk cycles per bit.
module matrix_bit_shifter
  import matrix_pkg::*;
#(
  parameter int unsigned CntW = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [WORD_BITS-1:0] word_i,
  input  logic [CntW-1:0]      last_bit_i,  // bit count minus one
  output logic                 strip_clk_o,
  output logic                 strip_data_o,
  output logic                 last_o
);

  logic                 active_q, active_d;
  logic                 phase_q, phase_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [WORD_BITS-1:0] sreg_q, sreg_d;

  // Bit timing: phase 0 presents the bit with clk low, phase 1 raises clk.
  always_comb begin
    active_d = active_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    sreg_d   = sreg_q;
    if (load_i) begin
      active_d = 1'b1;
      phase_d  = 1'b0;
      cnt_d    = last_bit_i;
      sreg_d   = word_i;
    end else if (active_q) begin
      if (!phase_q) begin
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
        if (cnt_q == '0) begin
          active_d = 1'b0;
        end else begin
          cnt_d  = cnt_q - 1'b1;
          sreg_d = {sreg_q[WORD_BITS-2:0], 1'b0};
        end
      end
    end
  end

  // Shifter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      phase_q  <= 1'b0;
      cnt_q    <= '0;
      sreg_q   <= '0;
    end else begin
      active_q <= active_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      sreg_q   <= sreg_d;
    end
  end

  assign strip_clk_o  = active_q & phase_q;
  assign strip_data_o = active_q & sreg_q[WORD_BITS-1];
  assign last_o       = active_q & phase_q & (cnt_q == '0);

endmodule

// File: rtl/matrix_frame_sequencer.sv
// Frame sequencer for an APA102-style LED matrix: start frame, pixel words, end frame.
// Optional macro SERPENTINE_EN maps send order onto zig-zag row wiring for pix_idx.
module matrix_frame_sequencer
  import matrix_pkg::*;
#(
  parameter int unsigned NUM_PIXELS  = 64,
  parameter int unsigned ROW_LEN     = 8,
  parameter int unsigned NUM_GLYPHS  = 4,
  parameter int unsigned END_BITS    = 64,
  parameter int unsigned HOLD_CYCLES = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  matrix_frame_sequencer_if.master  pix_if,
  output logic                      strip_clk,
  output logic                      strip_data,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int unsigned PixW    = $clog2(NUM_PIXELS);
  localparam int unsigned GlyphW  = $clog2(NUM_GLYPHS);
  localparam int unsigned HoldW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned MaxBits = (END_BITS > WORD_BITS) ? END_BITS : WORD_BITS;
  localparam int unsigned CntW    = $clog2(MaxBits);

`ifdef SERPENTINE_EN
  localparam bit SerpEn = 1'b1;
`else
  localparam bit SerpEn = 1'b0;
`endif

  state_e              state_q, state_d;
  logic [PixW-1:0]     pix_cnt_q, pix_cnt_d;
  logic [GlyphW-1:0]   glyph_q, glyph_d;
  logic [HoldW-1:0]    hold_cnt_q, hold_cnt_d;
  logic                frame_done_q, frame_done_d;
  logic                frame_end;
  logic                sh_load, sh_last;
  logic [WORD_BITS-1:0] sh_word;
  logic [CntW-1:0]     sh_last_bit;
  logic [PixW-1:0]     map_idx;

  matrix_bit_shifter #(
    .CntW (CntW)
  ) u_shifter (
    .clk          (clk),
    .rst          (rst),
    .load_i       (sh_load),
    .word_i       (sh_word),
    .last_bit_i   (sh_last_bit),
    .strip_clk_o  (strip_clk),
    .strip_data_o (strip_data),
    .last_o       (sh_last)
  );

  assign map_idx = SerpEn ? PixW'(serp_idx(32'(pix_cnt_q), ROW_LEN)) : pix_cnt_q;

  // Next-state logic; each shifter load is issued in the cycle before its segment starts.
  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    glyph_d      = glyph_q;
    hold_cnt_d   = hold_cnt_q;
    frame_done_d = 1'b0;
    frame_end    = 1'b0;
    sh_load      = 1'b0;
    sh_word      = '0;
    sh_last_bit  = CntW'(START_BITS - 1);
    unique case (state_q)
      StIdle: begin
        if (run) begin
          state_d = StStart;
          sh_load = 1'b1;
        end
      end
      StStart: begin
        if (sh_last) state_d = StFetch;
      end
      StFetch: begin
        if (pix_if.pix_ack) begin
          state_d     = StShift;
          sh_load     = 1'b1;
          sh_word     = pix_if.pix_word;
          sh_last_bit = CntW'(WORD_BITS - 1);
        end
      end
      StShift: begin
        if (sh_last) begin
          if (pix_cnt_q == PixW'(NUM_PIXELS - 1)) begin
            pix_cnt_d   = '0;
            state_d     = StEnd;
            sh_load     = 1'b1;
            sh_last_bit = CntW'(END_BITS - 1);
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
            state_d   = StFetch;
          end
        end
      end
      StEnd: begin
        if (sh_last) begin
          frame_done_d = 1'b1;
          if (HOLD_CYCLES == 0) begin
            frame_end = 1'b1;
          end else begin
            state_d    = StHold;
            hold_cnt_d = '0;
          end
        end
      end
      StHold: begin
        if (hold_cnt_q == HoldW'(HOLD_CYCLES - 1)) frame_end = 1'b1;
        else hold_cnt_d = hold_cnt_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
    // Between frames: keep cycling glyphs while run is held, otherwise park.
    if (frame_end) begin
      if (run) begin
        state_d     = StStart;
        sh_load     = 1'b1;
        sh_last_bit = CntW'(START_BITS - 1);
        glyph_d     = (glyph_q == GlyphW'(NUM_GLYPHS - 1)) ? '0 : glyph_q + 1'b1;
      end else begin
        state_d = StIdle;
        glyph_d = '0;
      end
    end
  end

  // FSM and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      pix_cnt_q    <= '0;
      glyph_q      <= '0;
      hold_cnt_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      glyph_q      <= glyph_d;
      hold_cnt_q   <= hold_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pix_if.pix_req   = (state_q == StFetch);
  assign pix_if.pix_idx   = (state_q == StFetch) ? map_idx : '0;
  assign pix_if.glyph_idx = glyph_q;
  assign busy             = (state_q != StIdle);
  assign frame_done       = frame_done_q;

endmodule

// File: tb/tb_matrix_frame_sequencer.sv
// Scoreboard bench for matrix_frame_sequencer: acked words are queued and matched
// against the serial stream reassembled from strip_clk rising edges.
module tb_matrix_frame_sequencer;
  import matrix_pkg::*;

  localparam int unsigned NPix    = 64;
  localparam int unsigned RowLen  = 8;
  localparam int unsigned NGly    = 4;
  localparam int unsigned EndBits = 64;
  localparam int unsigned ExpEdges = START_BITS + NPix * WORD_BITS + EndBits;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic strip_clk, strip_data, busy, frame_done;

  matrix_frame_sequencer_if #(.IdxW(6), .GlyphW(2)) pix_if ();

  matrix_frame_sequencer #(
    .NUM_PIXELS  (NPix),
    .ROW_LEN     (RowLen),
    .NUM_GLYPHS  (NGly),
    .END_BITS    (EndBits),
    .HOLD_CYCLES (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .pix_if     (pix_if),
    .strip_clk  (strip_clk),
    .strip_data (strip_data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_idx(input int p);
`ifdef SERPENTINE_EN
    int r;
    int c;
    r = p / RowLen;
    c = p % RowLen;
    return (r % 2 == 0) ? (r * RowLen + RowLen - 1 - c) : p;
`else
    return p;
`endif
  endfunction

  logic [31:0] exp_pix_q[$];
  int          ack_dly     = 0;
  bit          spurious    = 1'b0;
  bit          fixed_word  = 1'b1;
  int          resp_pix    = 0;
  int          wait_cnt    = 0;
  int          frames_in_run = 0;
  logic [5:0]  idx_at_req;
  logic [31:0] w;

  // Pixel source: acks ack_dly cycles after the request appears, queues the word sent.
  always @(negedge clk) begin
    if (rst) begin
      pix_if.pix_ack  = 1'b0;
      pix_if.pix_word = '0;
      resp_pix        = 0;
      wait_cnt        = 0;
    end else if (pix_if.pix_req) begin
      if (wait_cnt == 0) idx_at_req = pix_if.pix_idx;
      if (wait_cnt == ack_dly) begin
        w = fixed_word ? 32'hF00F0000 : $urandom;
        pix_if.pix_ack  = 1'b1;
        pix_if.pix_word = w;
        exp_pix_q.push_back(w);
        check("pix_idx", 32'(pix_if.pix_idx), 32'(exp_idx(resp_pix)));
        if (ack_dly > 0) check("idx_stable", 32'(pix_if.pix_idx), 32'(idx_at_req));
        if (resp_pix == 0) check("glyph_idx", 32'(pix_if.glyph_idx), 32'(frames_in_run % NGly));
        resp_pix = (resp_pix == NPix - 1) ? 0 : resp_pix + 1;
        wait_cnt = 0;
      end else begin
        pix_if.pix_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      wait_cnt        = 0;
      pix_if.pix_ack  = spurious ? 1'($urandom) : 1'b0;
      pix_if.pix_word = $urandom;
    end
  end

  bit          prev_clk = 1'b0, prev_data = 1'b0, prev_busy = 1'b0;
  int          edges = 0, nbits = 0, pos = 0;
  int unsigned frame_start = 0;
  logic [31:0] sh = '0;
  logic [31:0] expw;

  // Strip monitor: reassembles 32-bit words and checks frame structure and timing.
  always @(negedge clk) begin
    if (rst) begin
      prev_clk = 1'b0; prev_data = 1'b0; prev_busy = 1'b0;
      edges = 0; nbits = 0; pos = 0; frames_in_run = 0;
      exp_pix_q.delete();
    end else begin
      if (pix_if.pix_req) check("fetch_clk_low", 32'(strip_clk), 32'd0);
      if (strip_clk && !prev_clk) begin
        check("data_hold", 32'(strip_data), 32'(prev_data));
        edges++;
        sh = {sh[30:0], strip_data};
        nbits++;
        if (nbits == 32) begin
          nbits = 0;
          if (pos == 0 || pos > int'(NPix)) begin
            check("zero_word", sh, 32'd0);
          end else if (exp_pix_q.size() == 0) begin
            check("sb_empty", 32'(exp_pix_q.size()), 32'd1);
          end else begin
            expw = exp_pix_q.pop_front();
            check("pix_word", sh, expw);
          end
          pos++;
        end
      end
      if (frame_done) begin
        check("edges", 32'(edges), 32'(ExpEdges));
        check("done_cycle", cyc - frame_start, BIT_CYCLES * ExpEdges + NPix * (1 + ack_dly));
        check("sb_left", 32'(exp_pix_q.size()), 32'd0);
        edges = 0; nbits = 0; pos = 0;
        frames_in_run = busy ? frames_in_run + 1 : 0;
        frame_start = cyc;
      end else if (busy && !prev_busy) begin
        frame_start = cyc;
      end
      prev_clk  = strip_clk;
      prev_data = strip_data;
      prev_busy = busy;
    end
  end

  task automatic wait_done(input int budget);
    int  n = 0;
    bit  seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (frame_done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_strip_clk", 32'(strip_clk), 32'd0);
    check("rst_strip_data", 32'(strip_data), 32'd0);
    check("rst_pix_req", 32'(pix_if.pix_req), 32'd0);
    check("rst_pix_idx", 32'(pix_if.pix_idx), 32'd0);
    check("rst_glyph", 32'(pix_if.glyph_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Zero-wait single frame with fixed word, run pulsed
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    wait_done(6000);
    check("busy_after", 32'(busy), 32'd0);
    check("glyph_after", 32'(pix_if.glyph_idx), 32'd0);
    repeat (3) @(negedge clk);
    check("busy_idle", 32'(busy), 32'd0);

    // Delayed ack, random words, spurious acks outside requests
    ack_dly = 4; spurious = 1'b1; fixed_word = 1'b0;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    wait_done(7000);
    spurious = 1'b0;
    repeat (2) @(negedge clk);
    ack_dly = 0;

    // Five back-to-back frames; run drops during the fifth
    run = 1'b1;
    for (int i = 0; i < 4; i++) wait_done(6000);
    run = 1'b0;
    wait_done(6000);
    check("busy_after_5", 32'(busy), 32'd0);
    check("glyph_after_5", 32'(pix_if.glyph_idx), 32'd0);

    // Reset during SHIFT of word 10, then a clean restart
    run = 1'b1;
    n = 0;
    while (resp_pix != 11 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("reached_word10", 32'(resp_pix), 32'd11);
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_strip_clk", 32'(strip_clk), 32'd0);
    check("mid_rst_strip_data", 32'(strip_data), 32'd0);
    check("mid_rst_pix_req", 32'(pix_if.pix_req), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("restart_busy", 32'(busy), 32'd1);
    run = 1'b0;
    wait_done(6000);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares",
             vectors, errors);
    $fatal(1, "watchdog");
  end

endmodule
